// File: rtl/wb_write_queue_pkg.sv
// Shared widths and the queue entry layout for the register-file write queue.
package wb_write_queue_pkg;
  localparam int ARCH_BITS        = 32;
  localparam int WB_DATA_WIDTH    = ARCH_BITS;
  localparam int WB_REG_ADDR_BITS = 5;
  localparam int WB_DEPTH         = 4;

  typedef struct packed {
    logic [WB_REG_ADDR_BITS-1:0] dst;
    logic [WB_DATA_WIDTH-1:0]    data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the occupied queue slots for one register read index.
module wb_fwd_match #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int DEPTH         = 4,
  parameter int PTR_W         = $clog2(DEPTH),
  parameter int CNT_W         = PTR_W + 1
) (
  input  logic [REG_ADDR_BITS-1:0]            src,
  input  logic [DEPTH-1:0][REG_ADDR_BITS-1:0] dsts,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]    datas,
  input  logic [PTR_W-1:0]                    head,
  input  logic [CNT_W-1:0]                    count,
  output logic                                hit,
  output logic [DATA_WIDTH-1:0]               data
);
  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (dsts[idx] == src)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back queue merging memory and ALU results onto one register-file write port.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int REG_ADDR_BITS = WB_REG_ADDR_BITS,
  parameter int DEPTH         = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  input  logic [REG_ADDR_BITS-1:0] mem_dst,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [REG_ADDR_BITS-1:0] alu_dst,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     wb_stall,
  output logic                     wb_we,
  output logic [REG_ADDR_BITS-1:0] wb_dst,
  output logic [DATA_WIDTH-1:0]    wb_data,
  input  logic [REG_ADDR_BITS-1:0] fwd_src1,
  input  logic [REG_ADDR_BITS-1:0] fwd_src2,
  output logic                     fwd_hit1,
  output logic [DATA_WIDTH-1:0]    fwd_data1,
  output logic                     fwd_hit2,
  output logic [DATA_WIDTH-1:0]    fwd_data2
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][REG_ADDR_BITS-1:0] dst_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    data_q;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, free, n_push;
  logic             mem_push, alu_push, empty;

  // Valid/ready: a source transfers on a cycle where valid and ready are both high;
  // ready depends only on the registered count and mem_valid, never on alu_valid.
  assign free      = CNT_W'(DEPTH) - count;
  assign mem_ready = (free >= CNT_W'(1));
  assign alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_valid);
  assign mem_push  = mem_valid && mem_ready;
  assign alu_push  = alu_valid && alu_ready;
  assign n_push    = CNT_W'(mem_push) + CNT_W'(alu_push);

  assign empty   = (count == '0);
  assign wb_we   = !empty && !wb_stall;
  assign wb_dst  = empty ? '0 : dst_q[head];
  assign wb_data = empty ? '0 : data_q[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(n_push);
      head  <= head + PTR_W'(wb_we);
      count <= count + n_push - CNT_W'(wb_we);
    end
  end

  // Memory is the older of two same-cycle results, so it takes the tail slot first.
  always_ff @(posedge clk) begin
    if (!rst && mem_push) begin
      dst_q[tail]  <= mem_dst;
      data_q[tail] <= mem_data;
    end
    if (!rst && alu_push) begin
      dst_q[tail + PTR_W'(mem_push)]  <= alu_dst;
      data_q[tail + PTR_W'(mem_push)] <= alu_data;
    end
  end

  wb_fwd_match #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_BITS(REG_ADDR_BITS), .DEPTH(DEPTH)
  ) u_fwd1 (
    .src(fwd_src1), .dsts(dst_q), .datas(data_q), .head(head), .count(count),
    .hit(fwd_hit1), .data(fwd_data1)
  );

  wb_fwd_match #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_BITS(REG_ADDR_BITS), .DEPTH(DEPTH)
  ) u_fwd2 (
    .src(fwd_src2), .dsts(dst_q), .datas(data_q), .head(head), .count(count),
    .hit(fwd_hit2), .data(fwd_data2)
  );
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench: driver issues vectors, a scoreboard queue holds expected write-backs.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  localparam int DW    = WB_DATA_WIDTH;
  localparam int AW    = WB_REG_ADDR_BITS;
  localparam int DEPTH = WB_DEPTH;
  localparam int EW    = $bits(wb_entry_t);

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, alu_valid, wb_stall;
  logic [AW-1:0] mem_dst, alu_dst, fwd_src1, fwd_src2;
  logic [DW-1:0] mem_data, alu_data;
  logic          mem_ready, alu_ready, wb_we, fwd_hit1, fwd_hit2;
  logic [AW-1:0] wb_dst;
  logic [DW-1:0] wb_data, fwd_data1, fwd_data2;

  wb_write_queue dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
    .wb_stall(wb_stall), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .fwd_src1(fwd_src1), .fwd_src2(fwd_src2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_count = 0;
  logic acc_m, acc_a, exp_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-back presented must be the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && wb_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: got dst=%0d data=0x%0h expected no write at %0t",
                 wb_dst, wb_data, $time);
      end else begin
        chk("wb_entry", 64'({wb_dst, wb_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mdat,
                       input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] adat,
                       input logic stall);
    mem_valid = mv; mem_dst = md; mem_data = mdat;
    alu_valid = av; alu_dst = ad; alu_data = adat;
    wb_stall  = stall;
  endtask

  // Mid-cycle checks of handshake and drain against the occupancy model.
  task automatic at_neg();
    logic exp_mr, exp_ar;
    int free;
    @(negedge clk);
    free   = DEPTH - m_count;
    exp_mr = (free >= 1);
    exp_ar = (free >= 2) || (free == 1 && !mem_valid);
    exp_we = (m_count != 0) && !wb_stall;
    acc_m  = mem_valid && exp_mr;
    acc_a  = alu_valid && exp_ar;
    chk("mem_ready", 64'(mem_ready), 64'(exp_mr));
    chk("alu_ready", 64'(alu_ready), 64'(exp_ar));
    chk("wb_we", 64'(wb_we), 64'(exp_we));
    if (m_count == 0) chk("wb_empty_out", 64'({wb_dst, wb_data}), 64'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      if (acc_m) exp_q.push_back({mem_dst, mem_data});
      if (acc_a) exp_q.push_back({alu_dst, alu_data});
      m_count = m_count + int'(acc_m) + int'(acc_a) - int'(exp_we);
    end
    #1;
  endtask

  task automatic cyc(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mdat,
                     input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] adat,
                     input logic stall);
    drive(mv, md, mdat, av, ad, adat, stall);
    at_neg();
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    fwd_src1 = '0;
    fwd_src2 = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("rst_wb", 64'({wb_we, wb_dst, wb_data}), 64'(0));
    chk("rst_fwd", 64'({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2}), 64'(0));
    chk("rst_ready", 64'({mem_ready, alu_ready}), 64'(2'b11));
    tick();

    // Single ALU result: write-back on the next cycle, then idle
    cyc(0, 0, 0, 1, 3, 32'hAAAA5555, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("t1_wb", 64'({wb_we, wb_dst, wb_data}), 64'({1'b1, 5'd3, 32'hAAAA5555}));
    tick();
    idle(1);

    // Same-cycle mem and ALU to r4: memory is older, ALU value forwards
    fwd_src1 = 5'd4;
    cyc(1, 4, 32'h11, 1, 4, 32'h22, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    at_neg();
    chk("t2_fwd_both_stall", 64'({fwd_hit1, fwd_data1}), 64'({1'b1, 32'h22}));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("t2_fwd_both", 64'({fwd_hit1, fwd_data1}), 64'({1'b1, 32'h22}));
    chk("t2_first_wb", 64'(wb_data), 64'(32'h11));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("t2_fwd_alu_only", 64'({fwd_hit1, fwd_data1}), 64'({1'b1, 32'h22}));
    tick();
    idle(1);

    // Stalled fill: mem wins the last slot, full blocks both, release drains in order
    cyc(1, 1, 32'h31, 0, 0, 0, 1);
    cyc(1, 2, 32'h32, 1, 3, 32'h33, 1);
    drive(1, 4, 32'h34, 1, 5, 32'hBAD4, 1);
    at_neg();
    chk("t3_last_slot", 64'({mem_ready, alu_ready}), 64'(2'b10));
    tick();
    drive(1, 6, 32'hBAD5, 1, 7, 32'hBAD6, 1);
    at_neg();
    chk("t3_full_ready", 64'({mem_ready, alu_ready}), 64'(2'b00));
    tick();
    idle(4);
    chk("t3_drained", 64'(exp_q.size()), 64'(0));

    // Fill then drain six across wrap with interleaved ALU pushes
    cyc(1, 8, 32'h41, 1, 9, 32'h42, 1);
    cyc(1, 10, 32'h43, 1, 11, 32'h44, 1);
    cyc(0, 0, 0, 1, 12, 32'hBAD7, 0);
    cyc(0, 0, 0, 1, 12, 32'h45, 0);
    cyc(0, 0, 0, 1, 13, 32'h46, 0);
    idle(4);
    chk("t4_drained", 64'(exp_q.size()), 64'(0));

    // Reset with entries queued and a push in flight
    fwd_src1 = 5'd5;
    fwd_src2 = 5'd6;
    cyc(1, 5, 32'h51, 1, 6, 32'h52, 1);
    cyc(1, 5, 32'h53, 0, 0, 0, 1);
    rst = 1'b1;
    cyc(1, 6, 32'h54, 1, 5, 32'h55, 1);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("t5_we", 64'(wb_we), 64'(0));
    chk("t5_fwd_hits", 64'({fwd_hit1, fwd_hit2}), 64'(0));
    chk("t5_ready", 64'({mem_ready, alu_ready}), 64'(2'b11));
    tick();
    idle(3);

    // Forward only from the cycle after acceptance
    fwd_src2 = 5'd7;
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("t6_miss", 64'({fwd_hit2, fwd_data2}), 64'(0));
    tick();
    drive(0, 0, 0, 1, 7, 32'h77, 0);
    at_neg();
    chk("t6_same_cycle", 64'({fwd_hit2, fwd_data2}), 64'(0));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("t6_hit", 64'({fwd_hit2, fwd_data2}), 64'({1'b1, 32'h77}));
    tick();
    idle(2);
    chk("final_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writer-side companion to the processor register file.
- Collects completed results from two producers (ALU, memory) into a small in-order queue.
- Drains one entry per cycle onto the register file's single write port (dst/wData/writeEnable).
- Provides youngest-match forwarding for the two register read indices, so decode sees values still in flight.

Parameters:
- DATA_WIDTH, 32 (equals proc.ARCH_BITS): result/data width.
- REG_ADDR_BITS, 5: register index width.
- DEPTH, 4: queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- mem_valid  in  1  memory result present.
- mem_dst  in  REG_ADDR_BITS  memory result destination.
- mem_data  in  DATA_WIDTH  memory result value.
- mem_ready  out  1  memory result accepted this cycle if mem_valid.
- alu_valid  in  1  ALU result present.
- alu_dst  in  REG_ADDR_BITS  ALU result destination.
- alu_data  in  DATA_WIDTH  ALU result value.
- alu_ready  out  1  ALU result accepted this cycle if alu_valid.
- wb_stall  in  1  register file write port unavailable this cycle.
- wb_we  out  1  to register file writeEnable.
- wb_dst  out  REG_ADDR_BITS  to register file dst.
- wb_data  out  DATA_WIDTH  to register file wData.
- fwd_src1  in  REG_ADDR_BITS  read index 1 (same as register file src1).
- fwd_src2  in  REG_ADDR_BITS  read index 2.
- fwd_hit1  out  1  queue holds a pending write to fwd_src1.
- fwd_data1  out  DATA_WIDTH  youngest pending value for fwd_src1; 0 when no hit.
- fwd_hit2  out  1  as fwd_hit1, for fwd_src2.
- fwd_data2  out  DATA_WIDTH  as fwd_data1, for fwd_src2.

Behaviour:
- Storage: circular buffer with head/tail pointers (log2 DEPTH bits, natural wrap) and count (0..DEPTH).
- Reset: count=0, head=tail=0.
  - Outputs after reset: wb_we=0, wb_dst=0, wb_data=0, fwd_hit*=0, fwd_data*=0, mem_ready=1, alu_ready=1.
  - Reset mid-operation discards all entries; rst has priority over push and pop.
- Ready rule: computed from registered count only; a same-cycle pop gives no credit.
  - free = DEPTH - count.
  - mem_ready = (free>=1).
  - alu_ready = (free>=2) or (free==1 and !mem_valid).
  - Memory wins the last slot; ready never depends on alu_valid (no combinational loop).
- Push: handshake = valid & ready.
  - If both handshake in the same cycle, memory entry is written at tail and ALU entry at tail+1 (memory is treated as older).
  - Tail advances by the number of pushes.
- Drain: wb_we = (count!=0) & !wb_stall.
  - wb_dst/wb_data are combinational from the head entry; they are 0 when empty.
  - On posedge with wb_we, head advances by 1. Latency push→wb_we is 1 cycle minimum.
- Simultaneous pop and push: count_next = count + pushes - pop; never exceeds DEPTH.
- Full (count==DEPTH): both readies 0. Empty: wb_we=0.
- No special case for register 0; every index is written as given.
- Forwarding: combinational search over valid entries (head..tail-1).
  - The youngest match (closest to tail) wins.
  - The head entry being written this cycle still forwards, because the register file updates only at the edge.
  - Entries pushed in the current cycle are not forwarded.
- Duplicate dst in the queue is legal; all entries drain in order, so the final register value equals the youngest.

Decomposition:
- Shared package: DATA_WIDTH/REG_ADDR_BITS derived from proc.ARCH_BITS; wb_entry struct {dst, data}.
- One natural sub-module: wb_fwd_match, the per-read-port youngest-match priority search. Instantiate it twice.

Test Plan:
- After rst, alu_valid=1, dst=3, data=0xAAAA5555 → next cycle wb_we=1, wb_dst=3, wb_data=0xAAAA5555; one cycle later wb_we=0.
- Same cycle mem (dst=4, 0x11) and alu (dst=4, 0x22) → wb order: 0x11 then 0x22; fwd_src1=4 returns 0x22 while both are queued, 0x22 while only the ALU entry remains.
- wb_stall=1 and 4 pushes → count=4, mem_ready=alu_ready=0; with count=3 and both valid → only mem accepted; release stall → 4 consecutive writes in push order.
- Fill, then drain 6 entries across pointer wrap with interleaved pushes → wb sequence matches push order exactly; no loss or duplication.
- rst asserted with 3 entries queued and push active → next cycle wb_we=0, fwd_hit1=fwd_hit2=0, readies 1; no queued data appears afterwards.
- fwd_src2=7 with no entry for 7 → fwd_hit2=0, fwd_data2=0; push dst=7 → hit only from the cycle after acceptance.
